// File: rtl/sp_ram_arb.sv
`default_nettype none
// ============================================================================
// sp_ram_arb : two-requester round-robin arbiter for one single-port 64-bit RAM
// Optional power-up zero sweep with macro SP_RAM_ARB_INIT_EN.     Rev 1.0
// ============================================================================
module sp_ram_arb #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_DEPTH = 1024,
  parameter int unsigned OUT_REGS   = 0
) (
  input  logic                    Clk_CI,
  input  logic                    Rst_RBI,
  input  logic [1:0]              Req_SI,
  output logic [1:0]              Gnt_SO,
  input  logic [1:0]              WrEn_SI,
  input  logic [15:0]             BEn_SI,
  input  logic [127:0]            WrData_DI,
  input  logic [2*ADDR_WIDTH-1:0] Addr_DI,
  output logic [1:0]              RValid_SO,
  output logic [63:0]             RdData_DO,
  output logic [1:0]              Err_SO,
  output logic                    InitDone_SO,
  output logic                    RamCSel_SO,
  output logic                    RamWrEn_SO,
  output logic [7:0]              RamBEn_SO,
  output logic [63:0]             RamWrData_DO,
  output logic [ADDR_WIDTH-1:0]   RamAddr_DO,
  input  logic [63:0]             RamRdData_DI
);

  localparam int unsigned LAT = 1 + OUT_REGS;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                  state_q;
  logic                    done_q;
  logic                    rr_q, rr_d;
  logic [1:0]              gnt;
  logic                    any_gnt;
  logic                    sel;
  logic [ADDR_WIDTH-1:0]   addr_sel;
  logic                    oor;
  logic [2:0]              pipe_q [LAT];  // {out-of-range, owner one-hot}
`ifdef SP_RAM_ARB_INIT_EN
  logic [ADDR_WIDTH-1:0]   cnt_q;
`endif

  // rr_q names the requester that wins the next conflict.
  always_comb begin
    gnt = 2'b00;
    if (Rst_RBI && state_q == RUN) begin
      case (Req_SI)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign any_gnt  = |gnt;
  assign sel      = gnt[1];
  assign addr_sel = sel ? Addr_DI[2*ADDR_WIDTH-1:ADDR_WIDTH] : Addr_DI[ADDR_WIDTH-1:0];
  assign oor      = ({1'b0, addr_sel} >= (ADDR_WIDTH+1)'(DATA_DEPTH));
  assign rr_d     = any_gnt ? ~sel : rr_q;

  assign Gnt_SO      = gnt;
  assign Err_SO      = (any_gnt && oor) ? gnt : 2'b00;
  assign InitDone_SO = done_q;

  always_comb begin
    RamCSel_SO   = any_gnt & ~oor;
    RamWrEn_SO   = WrEn_SI[sel];
    RamBEn_SO    = sel ? BEn_SI[15:8] : BEn_SI[7:0];
    RamWrData_DO = sel ? WrData_DI[127:64] : WrData_DI[63:0];
    RamAddr_DO   = addr_sel;
`ifdef SP_RAM_ARB_INIT_EN
    if (state_q == INIT) begin
      RamCSel_SO   = 1'b1;
      RamWrEn_SO   = 1'b1;
      RamBEn_SO    = 8'hFF;
      RamWrData_DO = 64'h0;
      RamAddr_DO   = cnt_q;
    end
`endif
  end

  assign RValid_SO = pipe_q[LAT-1][1:0];
  assign RdData_DO = (|pipe_q[LAT-1][1:0] && !pipe_q[LAT-1][2]) ? RamRdData_DI : 64'h0;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
`ifdef SP_RAM_ARB_INIT_EN
      state_q <= INIT;
      done_q  <= 1'b0;
      cnt_q   <= '0;
`else
      state_q <= RUN;
      done_q  <= 1'b1;
`endif
      rr_q <= 1'b0;
      for (int i = 0; i < LAT; i++) pipe_q[i] <= 3'b000;
    end else begin
      rr_q      <= rr_d;
      pipe_q[0] <= (any_gnt && !WrEn_SI[sel]) ? {oor, gnt} : 3'b000;
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
`ifdef SP_RAM_ARB_INIT_EN
      if (state_q == INIT) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == ADDR_WIDTH'(DATA_DEPTH - 1)) begin
          state_q <= RUN;
          done_q  <= 1'b1;
        end
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_arb.sv
`default_nettype none
// ============================================================================
// tb_sp_ram_arb : scoreboard bench, two instances (depth 1000/lat 1, depth 16/lat 2)
// sharing one stimulus stream.                                    Rev 1.0
// ============================================================================
module tb_sp_ram_arb;

  localparam int AW = 10;

  typedef struct {
    int          due;
    logic [1:0]  own;
    logic [63:0] data;
  } rd_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req = '0;
  logic [1:0]   we = '0;
  logic [15:0]  ben = '0;
  logic [127:0] wdata = '0;
  logic [19:0]  addr = '0;

  logic [1:0]    gnt_o  [2];
  logic [1:0]    rval_o [2];
  logic [63:0]   rdat_o [2];
  logic [1:0]    err_o  [2];
  logic          idone  [2];
  logic          csel   [2];
  logic          rwe    [2];
  logic [7:0]    rben   [2];
  logic [63:0]   rwdat  [2];
  logic [AW-1:0] raddr  [2];
  logic [63:0]   rrdat  [2];

  logic [63:0] mem0 [1024];
  logic [63:0] mem1 [1024];
  logic [63:0] rd0, rd1a, rd1b;
  logic [63:0] sh [2][1024];
  rd_t         sbq [2][$];
  bit          rr_m [2];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  sp_ram_arb #(.ADDR_WIDTH(AW), .DATA_DEPTH(1000), .OUT_REGS(0)) u_dut0 (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Req_SI(req), .Gnt_SO(gnt_o[0]), .WrEn_SI(we),
    .BEn_SI(ben), .WrData_DI(wdata), .Addr_DI(addr), .RValid_SO(rval_o[0]),
    .RdData_DO(rdat_o[0]), .Err_SO(err_o[0]), .InitDone_SO(idone[0]),
    .RamCSel_SO(csel[0]), .RamWrEn_SO(rwe[0]), .RamBEn_SO(rben[0]),
    .RamWrData_DO(rwdat[0]), .RamAddr_DO(raddr[0]), .RamRdData_DI(rrdat[0]));

  sp_ram_arb #(.ADDR_WIDTH(AW), .DATA_DEPTH(16), .OUT_REGS(1)) u_dut1 (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Req_SI(req), .Gnt_SO(gnt_o[1]), .WrEn_SI(we),
    .BEn_SI(ben), .WrData_DI(wdata), .Addr_DI(addr), .RValid_SO(rval_o[1]),
    .RdData_DO(rdat_o[1]), .Err_SO(err_o[1]), .InitDone_SO(idone[1]),
    .RamCSel_SO(csel[1]), .RamWrEn_SO(rwe[1]), .RamBEn_SO(rben[1]),
    .RamWrData_DO(rwdat[1]), .RamAddr_DO(raddr[1]), .RamRdData_DI(rrdat[1]));

  function automatic logic [63:0] pat(input int i);
    return {16'hC0DE, 16'(i), ~16'(i), 16'h5A5A};
  endfunction

  function automatic int depth_of(input int d);
    return (d == 0) ? 1000 : 16;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  // Behavioural byte-enabled RAMs: 1-cycle for instance 0, 2-cycle for instance 1.
  initial for (int i = 0; i < 1024; i++) begin
    mem0[i] = pat(i);
    mem1[i] = pat(i);
  end

  always @(posedge clk) begin
    if (csel[0]) begin
      if (rwe[0]) begin
        for (int b = 0; b < 8; b++) if (rben[0][b]) mem0[raddr[0]][8*b +: 8] <= rwdat[0][8*b +: 8];
      end else begin
        rd0 <= mem0[raddr[0]];
      end
    end
  end

  always @(posedge clk) begin
    if (csel[1]) begin
      if (rwe[1]) begin
        for (int b = 0; b < 8; b++) if (rben[1][b]) mem1[raddr[1]][8*b +: 8] <= rwdat[1][8*b +: 8];
      end else begin
        rd1a <= mem1[raddr[1]];
      end
    end
    rd1b <= rd1a;
  end

  assign rrdat[0] = rd0;
  assign rrdat[1] = rd1b;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_rd();
    rd_t e;
    for (int d = 0; d < 2; d++) begin
      if (sbq[d].size() > 0 && sbq[d][0].due == cyc) begin
        e = sbq[d].pop_front();
        check_eq($sformatf("rvalid%0d", d), 64'(rval_o[d]), 64'(e.own));
        check_eq($sformatf("rdata%0d", d), rdat_o[d], e.data);
      end else begin
        check_eq($sformatf("rvalid_idle%0d", d), 64'(rval_o[d]), 64'h0);
        check_eq($sformatf("rdata_idle%0d", d), rdat_o[d], 64'h0);
      end
    end
  endtask

  task automatic model_cycle(input int d);
    logic [1:0]    eg;
    int            s;
    logic [AW-1:0] ad;
    logic [7:0]    be_s;
    logic [63:0]   wd_s;
    bit            oor;
    case (req)
      2'b01:   eg = 2'b01;
      2'b10:   eg = 2'b10;
      2'b11:   eg = rr_m[d] ? 2'b10 : 2'b01;
      default: eg = 2'b00;
    endcase
    check_eq($sformatf("gnt%0d", d), 64'(gnt_o[d]), 64'(eg));
    if (eg != 2'b00) begin
      s    = eg[1] ? 1 : 0;
      ad   = s ? addr[19:10] : addr[9:0];
      be_s = s ? ben[15:8] : ben[7:0];
      wd_s = s ? wdata[127:64] : wdata[63:0];
      oor  = (int'(ad) >= depth_of(d));
      check_eq($sformatf("err%0d", d), 64'(err_o[d]), oor ? 64'(eg) : 64'h0);
      check_eq($sformatf("csel%0d", d), 64'(csel[d]), oor ? 64'h0 : 64'h1);
      if (!oor) begin
        check_eq($sformatf("ramwe%0d", d), 64'(rwe[d]), 64'(we[s]));
        check_eq($sformatf("ramaddr%0d", d), 64'(raddr[d]), 64'(ad));
        if (we[s]) begin
          check_eq($sformatf("ramben%0d", d), 64'(rben[d]), 64'(be_s));
          check_eq($sformatf("ramwdata%0d", d), rwdat[d], wd_s);
          for (int b = 0; b < 8; b++) if (be_s[b]) sh[d][ad][8*b +: 8] = wd_s[8*b +: 8];
        end
      end
      if (!we[s]) sbq[d].push_back('{due: cyc + lat_of(d), own: eg, data: oor ? 64'h0 : sh[d][ad]});
      rr_m[d] = (s == 0);
    end else begin
      check_eq($sformatf("err_idle%0d", d), 64'(err_o[d]), 64'h0);
      check_eq($sformatf("csel_idle%0d", d), 64'(csel[d]), 64'h0);
    end
  endtask

  task automatic step(input logic [1:0] r, input logic [1:0] w, input logic [15:0] be,
                      input logic [127:0] wd, input logic [9:0] a1, input logic [9:0] a0);
    @(negedge clk);
    cyc++;
    check_rd();
    req = r; we = w; ben = be; wdata = wd; addr = {a1, a0};
    #1;
    for (int d = 0; d < 2; d++) model_cycle(d);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(2'b00, 2'b00, 16'h0, 128'h0, 10'd0, 10'd0);
  endtask

  task automatic wait_init();
    int n  = 0;
    int n1 = -1;
    while (!(idone[0] && idone[1]) && n < 1200) begin
      @(negedge clk);
      n++;
      if (n < 16) check_eq("init_addr", 64'(raddr[1]), 64'(n));
      if (idone[1] && n1 < 0) n1 = n;
    end
    check_eq("init_done_cycles", 64'(n1), 64'd16);
    check_eq("init_done_all", 64'(idone[0] && idone[1]), 64'h1);
  endtask

  task automatic do_reset(input bit wait_done);
    @(negedge clk);
    rst_n = 1'b0;
    req = 2'b11; we = 2'b00; addr = '0; ben = '0; wdata = '0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("rst_gnt%0d", d), 64'(gnt_o[d]), 64'h0);
      check_eq($sformatf("rst_rvalid%0d", d), 64'(rval_o[d]), 64'h0);
      check_eq($sformatf("rst_err%0d", d), 64'(err_o[d]), 64'h0);
      check_eq($sformatf("rst_rdata%0d", d), rdat_o[d], 64'h0);
`ifdef SP_RAM_ARB_INIT_EN
      check_eq($sformatf("rst_idone%0d", d), 64'(idone[d]), 64'h0);
`else
      check_eq($sformatf("rst_idone%0d", d), 64'(idone[d]), 64'h1);
`endif
    end
    repeat (2) @(negedge clk);
    req = 2'b00;
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      sbq[d].delete();
      rr_m[d] = 1'b0;
    end
    #1;
`ifdef SP_RAM_ARB_INIT_EN
    for (int d = 0; d < 2; d++) for (int i = 0; i < depth_of(d); i++) sh[d][i] = 64'h0;
    check_eq("init_first_addr", 64'(raddr[1]), 64'h0);
    check_eq("init_first_csel", 64'(csel[1]), 64'h1);
    if (wait_done) wait_init();
`else
    if (wait_done) check_eq("idone_after_rst", 64'(idone[0] && idone[1]), 64'h1);
`endif
  endtask

  initial begin
    logic [1:0]  r, w;
    logic [9:0]  a0, a1;
    for (int d = 0; d < 2; d++) for (int i = 0; i < 1024; i++) sh[d][i] = pat(i);

`ifdef SP_RAM_ARB_INIT_EN
    // Interrupt the sweep part-way; it must restart from address 0.
    do_reset(1'b0);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      check_eq("sweep_addr", 64'(raddr[1]), 64'(n));
    end
`endif
    do_reset(1'b1);

    // Conflict from reset: 01,10,01,10.
    for (int k = 0; k < 4; k++) step(2'b11, 2'b00, 16'h0, 128'h0, 10'd2, 10'd1);
    // Lone read of address 5.
    step(2'b01, 2'b00, 16'h0, 128'h0, 10'd0, 10'd5);
    idle(2);
    // Byte write from requester 1, then read back.
    step(2'b10, 2'b10, 16'h0F00, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, 10'd3, 10'd0);
    step(2'b10, 2'b00, 16'h0, 128'h0, 10'd3, 10'd0);
    // Zero byte-enable write still selects the RAM.
    step(2'b01, 2'b01, 16'h0000, {64'h0, 64'h1234_5678_9ABC_DEF0}, 10'd0, 10'd4);
    step(2'b01, 2'b00, 16'h0, 128'h0, 10'd0, 10'd4);
    // Range boundaries: 1000/999 for instance 0, 16/15 for instance 1.
    step(2'b01, 2'b00, 16'h0, 128'h0, 10'd0, 10'd1000);
    step(2'b10, 2'b00, 16'h0, 128'h0, 10'd999, 10'd0);
    step(2'b01, 2'b00, 16'h0, 128'h0, 10'd0, 10'd16);
    step(2'b10, 2'b00, 16'h0, 128'h0, 10'd15, 10'd0);
    step(2'b01, 2'b01, 16'h00FF, {64'h0, 64'hDEAD_BEEF_0000_0001}, 10'd0, 10'd20);
    step(2'b01, 2'b00, 16'h0, 128'h0, 10'd0, 10'd20);
    // Back-to-back reads, requester 0 then 1.
    step(2'b01, 2'b00, 16'h0, 128'h0, 10'd0, 10'd9);
    step(2'b10, 2'b00, 16'h0, 128'h0, 10'd10, 10'd0);
    idle(3);

    for (int k = 0; k < 200; k++) begin
      r  = 2'($urandom_range(0, 3));
      w  = 2'($urandom_range(0, 3));
      a0 = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 24));
      a1 = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 24));
      step(r, w, 16'($urandom), {$urandom, $urandom, $urandom, $urandom}, a1, a0);
    end
    idle(3);
    check_eq("sb_empty0", 64'(sbq[0].size()), 64'h0);
    check_eq("sb_empty1", 64'(sbq[1].size()), 64'h0);

    // Reset with reads in flight: nothing may come back afterwards.
    step(2'b01, 2'b00, 16'h0, 128'h0, 10'd0, 10'd7);
    do_reset(1'b1);
    idle(3);
    step(2'b11, 2'b00, 16'h0, 128'h0, 10'd6, 10'd8);
    step(2'b11, 2'b00, 16'h0, 128'h0, 10'd6, 10'd8);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sp_ram_arb.md
SP_RAM_ARB -- requirements
Module: sp_ram_arb

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 10: RAM address width.
REQ-002 SHALL provide parameter DATA_DEPTH, default 1024: number of valid words, at most 2**ADDR_WIDTH.
REQ-003 SHALL provide parameter OUT_REGS, default 0: RAM output-register stages (0 or 1), so RAM read latency = 1+OUT_REGS.
REQ-004 SHALL provide port Clk_CI  in  1  single clock; all logic rising-edge.
REQ-005 SHALL provide port Rst_RBI  in  1  asynchronous active-low reset.
REQ-006 SHALL provide port Req_SI  in  2  per-requester access request.
REQ-007 SHALL provide port Gnt_SO  out  2  per-requester grant; access occurs in a cycle with Req&Gnt.
REQ-008 SHALL provide port WrEn_SI  in  2  per-requester write (1) / read (0).
REQ-009 SHALL provide port BEn_SI  in  16  byte enables; requester i on bits [8i+7:8i].
REQ-010 SHALL provide port WrData_DI  in  128  write data; requester i on bits [64i+63:64i].
REQ-011 SHALL provide port Addr_DI  in  2*ADDR_WIDTH  word address; requester i on upper/lower half.
REQ-012 SHALL provide port RValid_SO  out  2  read-data-valid, one bit per requester.
REQ-013 SHALL provide port RdData_DO  out  64  shared read data, qualified by RValid_SO.
REQ-014 SHALL provide port Err_SO  out  2  one-cycle out-of-range flag per requester.
REQ-015 SHALL provide port InitDone_SO  out  1  high when requests may be granted.
REQ-016 SHALL provide RAM-side ports RamCSel_SO (1), RamWrEn_SO (1), RamBEn_SO (8), RamWrData_DO (64), RamAddr_DO (ADDR_WIDTH) as outputs and RamRdData_DI (64) as input, driving one single-port byte-enabled Nx64 RAM.

Function
REQ-017 SHALL contain a two-state FSM, INIT and RUN; Gnt_SO is 0 in INIT.
REQ-018 SHALL, in RUN, grant combinationally in the request cycle: one requester only; a lone requester is granted; on a conflict, the requester not granted most recently wins.
REQ-019 SHALL update the round-robin pointer only on a cycle with a grant; pointer reset value selects requester 0 on the first conflict.
REQ-020 SHALL drive the RAM-side outputs combinationally from the granted requester; RamCSel_SO=0 when no grant.
REQ-021 SHALL, for a granted in-range read, pulse RValid_SO[i] exactly 1+OUT_REGS cycles after the grant, with RdData_DO=RamRdData_DI.
REQ-022 SHALL track in-flight read owners in a 1+OUT_REGS-deep shift pipeline, sustaining back-to-back reads from either requester every cycle.
REQ-023 SHALL produce no RValid_SO for writes.
REQ-024 SHALL, for a granted request with Addr >= DATA_DEPTH, grant normally, hold RamCSel_SO=0, and pulse Err_SO[i] in the grant cycle; a read additionally returns RValid_SO[i] at normal latency with RdData_DO=0.
REQ-025 SHALL drive RdData_DO=0 in any cycle where RValid_SO is 0.
REQ-026 SHALL pass BEn_SI through unmodified; BEn=0 on a granted write still asserts RamCSel_SO and RamWrEn_SO.

Reset
REQ-027 SHALL, on reset, clear Gnt_SO, RValid_SO, Err_SO, RdData_DO, the read pipeline and the round-robin pointer, and clear the init counter to 0.
REQ-028 SHALL, on reset asserted mid-operation or mid-init, discard in-flight reads (no RValid_SO after release) and restart from the reset state.

Configuration
REQ-029 SHALL, with macro SP_RAM_ARB_INIT_EN defined, reset into INIT with InitDone_SO=0 and write 64'h0 with all byte enables to addresses 0..DATA_DEPTH-1, one per cycle, then enter RUN and set InitDone_SO=1 the cycle after address DATA_DEPTH-1 is written.
REQ-030 SHALL, without SP_RAM_ARB_INIT_EN, reset into RUN with InitDone_SO=1 and contain no init counter.

Verification
REQ-031 SHALL cover a lone read: Req_SI=01, Addr0=5, OUT_REGS=0 -> Gnt_SO=01 the same cycle, RValid_SO=01 the next cycle with the stored word.
REQ-032 SHALL cover a conflict: Req_SI=11 for 4 cycles from reset -> grants 01,10,01,10.
REQ-033 SHALL cover a byte write: requester 1 writes 64'hFFFF_FFFF_FFFF_FFFF with BEn=8'h0F to address 3, then reads it -> lower 32 bits 1s, upper bits unchanged.
REQ-034 SHALL cover out-of-range: DATA_DEPTH=1000, read at address 1000 -> Err_SO pulse, RamCSel_SO=0, RValid with RdData_DO=0.
REQ-035 SHALL cover init with SP_RAM_ARB_INIT_EN, DATA_DEPTH=16: InitDone_SO rises 16 cycles after reset release, all words read 0; reset at cycle 8 -> sweep restarts at address 0.
REQ-036 SHALL cover latency: OUT_REGS=1, back-to-back reads from requesters 0 then 1 -> RValid_SO=01 then 10, two cycles after their respective grants.
